// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL_DONE
  } state_t;

  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines);
    return 32 - OFFSET_W - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage for the cache, one line addressed per cycle.
// Latency: combinational read; word and line writes land on the rising edge.
// Backpressure: none; writes are accepted whenever enabled.
// Ports: clk/rst_n (sync clear of valid+dirty), idx selects the line for
// read and write; word_we writes one word and marks dirty; line_we installs
// a full line with its tag, valid=1, dirty=0 (line_we wins over word_we).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] data,
  input  logic              word_we,
  input  logic [2:0]        word_sel,
  input  logic [WORD_W-1:0] word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data are left unreset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[idx] <= line_data;
      tag_q[idx]  <= line_tag;
    end else if (word_we) begin
      data_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller for the MEM stage.
// Latency: hits complete in the same cycle; misses stall through write-back/refill.
// Backpressure: cpu_stall_o holds the pipeline; memory side waits on mem_ack_i.
// Ports: cpu_* is the pipeline load/store port (request held while stalled);
// mem_* is a line-wide req/ack port, mem_we_o=1 for victim write-back.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_BYTES = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W  = index_w(NUM_LINES);
  localparam int TAG_W  = tag_w(NUM_LINES);
  localparam int WSEL_W = $clog2(LINE_BYTES) - 2;

  state_t state, next_state;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              unused_bits;

  logic              arr_valid, arr_dirty;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_data;
  logic              word_we, line_we;
  logic              hit;

  assign idx         = cpu_addr_i[OFFSET_W +: IDX_W];
  assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
  assign word_sel    = cpu_addr_i[OFFSET_W-1:2];
  assign unused_bits = ^cpu_addr_i[1:0];

  dcache_array #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .idx       (idx),
    .valid     (arr_valid),
    .dirty     (arr_dirty),
    .tag       (arr_tag),
    .data      (arr_data),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .word_data (cpu_wdata_i),
    .line_we   (line_we),
    .line_tag  (cpu_tag),
    .line_data (mem_rdata_i)
  );

  assign hit = (state == IDLE) && cpu_req_i && arr_valid && (arr_tag == cpu_tag);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= next_state;
  end

  // The CPU request is held stable while stalled, so idx/cpu_tag keep
  // addressing the same line (and its victim) throughout a miss.
  always_comb begin
    next_state  = state;
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    word_we     = 1'b0;
    line_we     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            cpu_rdata_o = arr_data[word_sel*WORD_W +: WORD_W];
            word_we     = cpu_we_i;
          end else begin
            cpu_stall_o = 1'b1;
            next_state  = (arr_valid && arr_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        // Victim address uses the stored tag, not the incoming one.
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {arr_tag, idx, {OFFSET_W{1'b0}}};
        mem_wdata_o = arr_data;
        if (mem_ack_i) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_tag, idx, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          line_we    = 1'b1;
          next_state = REFILL_DONE;
        end
      end
      default: begin
        cpu_stall_o = 1'b1;
        next_state  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hit vectors from a table plus miss,
// write-back, reset-abort and long-latency sequences.
// Memory side is a responder with per-access ack delays.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;
  logic rd_wdata_bad = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_LINES(16), .LINE_BYTES(32)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = base + w;
    return l;
  endfunction

  // Presents one request and answers memory phases with the given ack delays
  // (ack asserted on request cycle index lw/lr of each phase). Returns the
  // stall count and what was seen on the memory bus. Called at posedge+1.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int lw, input int lr, input logic [255:0] fill,
                            output int stalls, output logic saw_wb, output logic [31:0] wb_addr,
                            output logic [255:0] wb_data, output logic [31:0] rd_addr,
                            output logic [31:0] rdata);
    int   cnt, phase, prev;
    logic done;
    stalls = 0; saw_wb = 0; wb_addr = '0; wb_data = '0; rd_addr = '0; rdata = '0;
    cnt = 0; prev = 0; done = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!cpu_stall) begin
        rdata = cpu_rdata;
        done  = 1'b1;
      end else begin
        stalls++;
        phase = mem_req ? (mem_we ? 1 : 2) : 0;
        cnt   = (phase == prev) ? cnt + 1 : 0;
        prev  = phase;
        if (phase == 1) begin
          saw_wb = 1'b1; wb_addr = mem_addr; wb_data = mem_wdata;
          if (cnt == lw) mem_ack = 1'b1;
        end else if (phase == 2) begin
          rd_addr = mem_addr;
          if (mem_wdata !== '0) rd_wdata_bad = 1'b1;
          if (cnt == lr) begin
            mem_ack = 1'b1; mem_rdata = fill;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("access_done", {255'b0, done}, 256'd1);
  endtask

  int           st;
  logic         swb;
  logic [31:0]  wba, rda, rdd;
  logic [255:0] wbd, exp_a, exp_c;
  logic         ok;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_011C, 32'h0,         1'b0, 32'hA000_0007};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0118, 32'h55AA_55AA, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0118, 32'h0,         1'b0, 32'h55AA_55AA};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,         1'b0, 32'hA000_0002};

    exp_a = mk_line(32'hA000_0000);
    exp_a[31:0] = 32'hDEAD_BEEF;

    // Reset with a request pending: everything quiet, stall mirrors request.
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    chk("rst_stall", {255'b0, cpu_stall}, 256'd1);
    chk("rst_mem_req", {255'b0, mem_req}, 256'd0);
    chk("rst_mem_we", {255'b0, mem_we}, 256'd0);
    chk("rst_mem_addr", {224'b0, mem_addr}, 256'd0);
    chk("rst_mem_wdata", mem_wdata, 256'd0);
    chk("rst_rdata", {224'b0, cpu_rdata}, 256'd0);
    rst_n = 1'b1;

    // Clean load miss, ack at L=2.
    run_access(1'b0, 32'h100, 32'h0, 0, 2, exp_a, st, swb, wba, wbd, rda, rdd);
    chk("fill_stalls", st, 5);
    chk("fill_no_wb", {255'b0, swb}, 256'd0);
    chk("fill_addr", {224'b0, rda}, 256'h100);
    chk("fill_rdata", {224'b0, rdd}, 256'hDEAD_BEEF);

    // Back-to-back hits from the table.
    foreach (vecs[i]) begin
      cpu_req = vecs[i].req; cpu_we = vecs[i].we;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_stall", i), {255'b0, cpu_stall}, {255'b0, vecs[i].exp_stall});
      chk($sformatf("vec%0d_mem_req", i), {255'b0, mem_req}, 256'd0);
      if (!vecs[i].we)
        chk($sformatf("vec%0d_rdata", i), {224'b0, cpu_rdata}, {224'b0, vecs[i].exp_rdata});
      tick();
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    exp_a[63:32]   = 32'h1234_5678;
    exp_a[223:192] = 32'h55AA_55AA;

    // Aliasing load with dirty victim: write-back of old address then refill.
    run_access(1'b0, 32'h2100, 32'h0, 1, 3, mk_line(32'hB000_0000), st, swb, wba, wbd, rda, rdd);
    chk("alias_stalls", st, 8);
    chk("alias_wb", {255'b0, swb}, 256'd1);
    chk("alias_wb_addr", {224'b0, wba}, 256'h100);
    chk("alias_wb_data", wbd, exp_a);
    chk("alias_rd_addr", {224'b0, rda}, 256'h2100);
    chk("alias_rdata", {224'b0, rdd}, 256'hB000_0000);

    // Store miss at L=0 into a clean line: allocate then write.
    run_access(1'b1, 32'h300, 32'hCAFE_F00D, 0, 0, mk_line(32'hC000_0000), st, swb, wba, wbd, rda, rdd);
    chk("smiss_stalls", st, 3);
    chk("smiss_no_wb", {255'b0, swb}, 256'd0);
    chk("smiss_rd_addr", {224'b0, rda}, 256'h300);
    run_access(1'b0, 32'h300, 32'h0, 0, 0, '0, st, swb, wba, wbd, rda, rdd);
    chk("smiss_hit_stalls", st, 0);
    chk("smiss_hit_rdata", {224'b0, rdd}, 256'hCAFE_F00D);

    // Evict the stored line: write-back must carry the stored word.
    exp_c = mk_line(32'hC000_0000);
    exp_c[31:0] = 32'hCAFE_F00D;
    run_access(1'b0, 32'h100, 32'h0, 0, 0, exp_a, st, swb, wba, wbd, rda, rdd);
    chk("evict_stalls", st, 4);
    chk("evict_wb_addr", {224'b0, wba}, 256'h300);
    chk("evict_wb_data", wbd, exp_c);
    chk("evict_rdata", {224'b0, rdd}, {224'b0, exp_a[31:0]});

    // Reset during ALLOCATE, late ack one cycle after.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
    #1;
    chk("rma_miss", {255'b0, cpu_stall}, 256'd1);
    tick();
    #1;
    chk("rma_alloc_req", {255'b0, mem_req}, 256'd1);
    chk("rma_alloc_addr", {224'b0, mem_addr}, 256'h400);
    rst_n = 1'b0;
    tick();
    chk("rma_req_drop", {255'b0, mem_req}, 256'd0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = mk_line(32'hD000_0000);
    #1;
    chk("rma_remiss_stall", {255'b0, cpu_stall}, 256'd1);
    chk("rma_ack_req", {255'b0, mem_req}, 256'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rma_ack_ignored", {255'b0, mem_req}, 256'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rma_refill_stall", {255'b0, cpu_stall}, 256'd1);
    tick();
    #1;
    chk("rma_hit_stall", {255'b0, cpu_stall}, 256'd0);
    chk("rma_hit_rdata", {224'b0, cpu_rdata}, 256'hD000_0000);
    tick();
    cpu_req = 1'b0;
    // Reset cleared every line, including the one at 0x100.
    run_access(1'b0, 32'h100, 32'h0, 0, 0, exp_a, st, swb, wba, wbd, rda, rdd);
    chk("rma_inval_stalls", st, 3);

    // Ack withheld 20 cycles: everything holds still.
    cpu_req = 1'b1; cpu_addr = 32'h500;
    #1;
    chk("hold_miss", {255'b0, cpu_stall}, 256'd1);
    tick();
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h500 || cpu_stall !== 1'b1)
        ok = 1'b0;
      tick();
    end
    chk("hold_stable", {255'b0, ok}, 256'd1);
    mem_ack = 1'b1; mem_rdata = mk_line(32'hE000_0000);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("hold_refill_stall", {255'b0, cpu_stall}, 256'd1);
    tick();
    #1;
    chk("hold_hit_stall", {255'b0, cpu_stall}, 256'd0);
    chk("hold_hit_rdata", {224'b0, cpu_rdata}, 256'hE000_0000);
    tick();
    cpu_req = 1'b0;

    chk("read_wdata_zero", {255'b0, rd_wdata_bad}, 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
